hwpe_sm_addrgen: RTL and testbench

//  Burst address generator/translator for the shared-memory HWPE wrapper. Accepts one accelerator-side
//  (catc) burst request, walks it beat by beat with a programmable stride and translates each beat,
//  for N_PORTS interleaved lanes in parallel, into cluster addresses via the pointer register file.

---
 rtl/hwpe_sm_addrgen.sv | 145 ++++++++++++++
 tb/tb_hwpe_sm_addrgen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_sm_addrgen.sv
// Burst address generator: walks one catc burst beat by beat and translates each beat into
// N_PORTS interleaved cluster addresses through the pointer table; registered valid/ready output.
module hwpe_sm_addrgen #(
  parameter int CLUS_ADDR_WIDTH        = 32,
  parameter int CATC_ADDR_WIDTH        = 32,
  parameter int BASE_ALIGNMENT_BIT     = 6,
  parameter int N_POINTERS             = 4,
  parameter int N_PORTS                = 1,
  parameter int LEN_WIDTH              = 8,
  parameter int BANK_SIZE              = 4096,
  parameter int CONTINUOUS_WEIGHTS_SET = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_clear,
  input  logic [N_POINTERS*CLUS_ADDR_WIDTH-1:0] i_reg_hwpe_params,
  input  logic                                  i_req_valid,
  output logic                                  o_req_ready,
  input  logic [CATC_ADDR_WIDTH-1:0]            i_req_add,
  input  logic [LEN_WIDTH-1:0]                  i_req_len,
  input  logic [CATC_ADDR_WIDTH-1:0]            i_req_stride,
  output logic                                  o_out_valid,
  input  logic                                  i_out_ready,
  output logic [N_PORTS*CLUS_ADDR_WIDTH-1:0]    o_out_add,
  output logic [N_PORTS-1:0]                    o_out_err,
  output logic                                  o_out_last,
  output logic                                  o_done
);

  localparam int LOG_POINTERS = (N_POINTERS > 1) ? $clog2(N_POINTERS) : 1;
  localparam int LOG_PORTS    = $clog2(N_PORTS);
  localparam int CW           = CLUS_ADDR_WIDTH;
  localparam int AW           = CATC_ADDR_WIDTH;
  localparam int BAB          = BASE_ALIGNMENT_BIT;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   r_state, w_next_state;
  logic [AW-1:0]            r_cur_add;
  logic [AW-1:0]            r_stride;
  logic [LEN_WIDTH-1:0]     r_rem;
  logic                     r_out_vld;
  logic [N_PORTS*CW-1:0]    r_out_add;
  logic [N_PORTS-1:0]       r_out_err;
  logic                     r_out_last;

  logic                     w_accept;
  logic                     w_gen;
  logic [BAB-1:0]           w_elem [N_PORTS];
  logic [LOG_POINTERS-1:0]  w_ptr  [N_PORTS];
  logic [CW-1:0]            w_base [N_PORTS];
  logic [CW-1:0]            w_off  [N_PORTS];
  logic [N_PORTS*CW-1:0]    w_lane_add;
  logic [N_PORTS-1:0]       w_lane_err;

  // Lane p sees the catc address with its lane id appended below it; an
  // unmatched pointer index leaves base at 0 and flags the lane.
  always_comb begin
    w_lane_add = '0;
    w_lane_err = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_elem[p]     = BAB'((r_cur_add << LOG_PORTS) | AW'(p));
      w_ptr[p]      = LOG_POINTERS'(((r_cur_add << LOG_PORTS) | AW'(p)) >> BAB);
      w_base[p]     = '0;
      w_lane_err[p] = 1'b1;
      for (int k = 0; k < N_POINTERS; k++) begin
        if (w_ptr[p] == LOG_POINTERS'(k)) begin
          w_base[p]     = i_reg_hwpe_params[k*CW +: CW];
          w_lane_err[p] = 1'b0;
        end
      end
      w_off[p] = (CONTINUOUS_WEIGHTS_SET != 0) ? CW'(BANK_SIZE * 4 * p) : '0;
      w_lane_add[p*CW +: CW] = (((w_base[p] >> 2) + CW'(w_elem[p])) << 2) + w_off[p];
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_gen        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_accept     = 1'b1;
          w_next_state = (i_req_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        w_gen = (r_rem != '0) && (!r_out_vld || i_out_ready);
        if (r_out_vld && i_out_ready && r_out_last) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cur_add  <= '0;
      r_stride   <= '0;
      r_rem      <= '0;
      r_out_vld  <= 1'b0;
      r_out_add  <= '0;
      r_out_err  <= '0;
      r_out_last <= 1'b0;
    end else if (i_clear) begin
      r_state    <= S_IDLE;
      r_cur_add  <= '0;
      r_stride   <= '0;
      r_rem      <= '0;
      r_out_vld  <= 1'b0;
      r_out_add  <= '0;
      r_out_err  <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cur_add <= i_req_add;
        r_rem     <= i_req_len;
        r_stride  <= i_req_stride;
      end
      // A beat already held and not yet taken keeps its payload untouched.
      if (w_gen) begin
        r_out_vld  <= 1'b1;
        r_out_add  <= w_lane_add;
        r_out_err  <= w_lane_err;
        r_out_last <= (r_rem == LEN_WIDTH'(1));
        r_cur_add  <= r_cur_add + r_stride;
        r_rem      <= r_rem - LEN_WIDTH'(1);
      end else if (r_out_vld && i_out_ready) begin
        r_out_vld  <= 1'b0;
        r_out_last <= 1'b0;
      end
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_out_valid = r_out_vld;
  assign o_out_add   = r_out_add;
  assign o_out_err   = r_out_err;
  assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_hwpe_sm_addrgen.sv
// Directed bench for hwpe_sm_addrgen: one-lane, two-lane (with and without bank offset)
// and three-pointer instances driven by the same request stream.
module tb_hwpe_sm_addrgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear, req_valid, out_ready;
  logic [31:0] req_add, req_stride;
  logic [7:0]  req_len;
  logic [127:0] params4;
  logic [95:0]  params3;

  assign params4 = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
  assign params3 = params4[95:0];

  logic        a_rdy, a_vld, a_last, a_done;
  logic [31:0] a_add;
  logic [0:0]  a_err;
  logic        b_rdy, b_vld, b_last, b_done;
  logic [63:0] b_add;
  logic [1:0]  b_err;
  logic        c_rdy, c_vld, c_last, c_done;
  logic [63:0] c_add;
  logic [1:0]  c_err;
  logic        d_rdy, d_vld, d_last, d_done;
  logic [31:0] d_add;
  logic [0:0]  d_err;

  int errors = 0;
  int checks = 0;

  hwpe_sm_addrgen #(.N_PORTS(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_reg_hwpe_params(params4),
    .i_req_valid(req_valid), .o_req_ready(a_rdy), .i_req_add(req_add), .i_req_len(req_len),
    .i_req_stride(req_stride), .o_out_valid(a_vld), .i_out_ready(out_ready), .o_out_add(a_add),
    .o_out_err(a_err), .o_out_last(a_last), .o_done(a_done));

  hwpe_sm_addrgen #(.N_PORTS(2), .CONTINUOUS_WEIGHTS_SET(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_reg_hwpe_params(params4),
    .i_req_valid(req_valid), .o_req_ready(b_rdy), .i_req_add(req_add), .i_req_len(req_len),
    .i_req_stride(req_stride), .o_out_valid(b_vld), .i_out_ready(out_ready), .o_out_add(b_add),
    .o_out_err(b_err), .o_out_last(b_last), .o_done(b_done));

  hwpe_sm_addrgen #(.N_PORTS(2), .CONTINUOUS_WEIGHTS_SET(0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_reg_hwpe_params(params4),
    .i_req_valid(req_valid), .o_req_ready(c_rdy), .i_req_add(req_add), .i_req_len(req_len),
    .i_req_stride(req_stride), .o_out_valid(c_vld), .i_out_ready(out_ready), .o_out_add(c_add),
    .o_out_err(c_err), .o_out_last(c_last), .o_done(c_done));

  hwpe_sm_addrgen #(.N_PORTS(1), .N_POINTERS(3)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_reg_hwpe_params(params3),
    .i_req_valid(req_valid), .o_req_ready(d_rdy), .i_req_add(req_add), .i_req_len(req_len),
    .i_req_stride(req_stride), .o_out_valid(d_vld), .i_out_ready(out_ready), .o_out_add(d_add),
    .o_out_err(d_err), .o_out_last(d_last), .o_done(d_done));

  // Presents one request for a single cycle (all instances are idle); returns on the
  // falling edge right after the accepting rising edge.
  task automatic send_req(input logic [31:0] a, input logic [7:0] l, input logic [31:0] s);
    @(negedge clk);
    req_valid = 1'b1; req_add = a; req_len = l; req_stride = s;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_add = '0; req_len = '0; req_stride = '0;
    #12;
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", a_rdy); end
    checks++; if ({a_vld, a_last, a_done} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {a_vld, a_last, a_done}); end
    checks++; if ({a_add, a_err} !== 33'h0) begin errors++; $display("FAIL reset_add_err got=%h exp=0", {a_add, a_err}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  // 0x45 -> pointer 1, element 5 -> 0x2000 + 5*4
  task automatic test_single;
    send_req(32'h45, 8'd1, 32'd1);
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL single_latency valid got=%b exp=0", a_vld); end
    @(negedge clk);
    checks++; if ({a_vld, a_last, a_err} !== 3'b110) begin errors++; $display("FAIL single_flags got=%b exp=110", {a_vld, a_last, a_err}); end
    checks++; if (a_add !== 32'h2014) begin errors++; $display("FAIL single_add got=%h exp=2014", a_add); end
    @(negedge clk);
    checks++; if ({a_done, a_vld} !== 2'b10) begin errors++; $display("FAIL single_done got=%b exp=10", {a_done, a_vld}); end
    @(negedge clk);
    checks++; if ({a_done, a_rdy} !== 2'b01) begin errors++; $display("FAIL single_idle got=%b exp=01", {a_done, a_rdy}); end
  endtask

  task automatic test_burst;
    logic [31:0] exp_add [4];
    exp_add[0] = 32'h10F8; exp_add[1] = 32'h10FC; exp_add[2] = 32'h2000; exp_add[3] = 32'h2004;
    send_req(32'h3E, 8'd4, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (a_vld !== 1'b1 || a_add !== exp_add[i] || a_last !== (i == 3)) begin
        errors++;
        $display("FAIL burst_beat%0d got vld=%b add=%h last=%b exp vld=1 add=%h last=%b",
                 i, a_vld, a_add, a_last, exp_add[i], (i == 3));
      end
    end
    @(negedge clk);
    checks++; if ({a_done, a_vld} !== 2'b10) begin errors++; $display("FAIL burst_done got=%b exp=10", {a_done, a_vld}); end
    @(negedge clk);
  endtask

  // ready is dropped for three cycles while the second beat is presented
  task automatic test_back_to_back_stall;
    logic [31:0] exp_add [4];
    int beat, hold;
    bit seen_done;
    exp_add[0] = 32'h10F8; exp_add[1] = 32'h10FC; exp_add[2] = 32'h2000; exp_add[3] = 32'h2004;
    beat = 0; hold = 0; seen_done = 1'b0;
    send_req(32'h3E, 8'd4, 32'd1);
    for (int cyc = 0; cyc < 30 && !seen_done; cyc++) begin
      @(negedge clk);
      if (a_done) seen_done = 1'b1;
      else if (a_vld) begin
        checks++;
        if (beat > 3 || a_add !== exp_add[beat & 3] || a_last !== (beat == 3)) begin
          errors++;
          $display("FAIL stall_beat%0d got add=%h last=%b exp add=%h last=%b",
                   beat, a_add, a_last, exp_add[beat & 3], (beat == 3));
        end
        if (beat == 1 && hold < 3) begin
          out_ready = 1'b0; hold++;
        end else begin
          out_ready = 1'b1; beat++;
        end
      end
    end
    out_ready = 1'b1;
    checks++; if (!seen_done || beat != 4 || hold != 3) begin errors++; $display("FAIL stall_total got done=%0d beats=%0d holds=%0d exp done=1 beats=4 holds=3", seen_done, beat, hold); end
    @(negedge clk);
  endtask

  // 0x3 -> lane0 catc 0x6, lane1 catc 0x7; lane1 bank offset 0x4000 only with offset enabled
  task automatic test_lanes;
    send_req(32'h3, 8'd1, 32'd1);
    @(negedge clk);
    checks++; if (b_add !== {32'h501C, 32'h1018}) begin errors++; $display("FAIL lanes_cont got=%h exp=0000501c00001018", b_add); end
    checks++; if (c_add !== {32'h101C, 32'h1018}) begin errors++; $display("FAIL lanes_nocont got=%h exp=0000101c00001018", c_add); end
    checks++; if ({b_vld, b_last, b_err} !== 4'b1100) begin errors++; $display("FAIL lanes_flags got=%b exp=1100", {b_vld, b_last, b_err}); end
    checks++; if (a_add !== 32'h100C) begin errors++; $display("FAIL lanes_single got=%h exp=100c", a_add); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty;
    send_req(32'h10, 8'd0, 32'd1);
    checks++; if ({a_done, a_vld, a_rdy} !== 3'b100) begin errors++; $display("FAIL empty_done got=%b exp=100", {a_done, a_vld, a_rdy}); end
    @(negedge clk);
    checks++; if ({a_done, a_vld, a_rdy} !== 3'b001) begin errors++; $display("FAIL empty_idle got=%b exp=001", {a_done, a_vld, a_rdy}); end
  endtask

  // 0xFFFFFFFF -> pointer 3, element 0x3F; +2 wraps to 0x1 -> pointer 0, element 1
  task automatic test_stride_wrap;
    send_req(32'hFFFF_FFFF, 8'd2, 32'd2);
    @(negedge clk);
    checks++; if ({a_add, a_last} !== {32'h40FC, 1'b0}) begin errors++; $display("FAIL wrap_beat0 got add=%h last=%b exp add=40fc last=0", a_add, a_last); end
    @(negedge clk);
    checks++; if ({a_add, a_last} !== {32'h1004, 1'b1}) begin errors++; $display("FAIL wrap_beat1 got add=%h last=%b exp add=1004 last=1", a_add, a_last); end
    repeat (2) @(negedge clk);
  endtask

  // three pointers: 0xC5 selects pointer 3 -> base 0 and error; 0x105 selects pointer 0
  task automatic test_ptr_err;
    send_req(32'hC5, 8'd2, 32'h40);
    @(negedge clk);
    checks++; if ({d_add, d_err} !== {32'h14, 1'b1}) begin errors++; $display("FAIL err_beat0 got add=%h err=%b exp add=14 err=1", d_add, d_err); end
    checks++; if ({a_add, a_err} !== {32'h4014, 1'b0}) begin errors++; $display("FAIL err_ref got add=%h err=%b exp add=4014 err=0", a_add, a_err); end
    @(negedge clk);
    checks++; if ({d_add, d_err, d_last} !== {32'h1014, 2'b01}) begin errors++; $display("FAIL err_beat1 got add=%h err=%b last=%b exp add=1014 err=0 last=1", d_add, d_err, d_last); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort(input bit use_clear);
    bit done_seen;
    done_seen = 1'b0;
    send_req(32'h40, 8'd8, 32'd1);
    repeat (3) @(negedge clk);
    checks++; if (a_add !== 32'h2008) begin errors++; $display("FAIL abort%0d_beat2 got=%h exp=2008", use_clear, a_add); end
    if (use_clear) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end else begin
      rst_n = 1'b0;
      #1;
    end
    checks++; if ({a_vld, a_rdy, a_done} !== 3'b010) begin errors++; $display("FAIL abort%0d_state got=%b exp=010", use_clear, {a_vld, a_rdy, a_done}); end
    if (!use_clear) begin
      @(negedge clk);
      rst_n = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_done || a_vld) done_seen = 1'b1;
    end
    checks++; if (done_seen) begin errors++; $display("FAIL abort%0d_quiet got done_or_valid=1 exp=0", use_clear); end
    test_single();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_back_to_back_stall();
    test_lanes();
    test_empty();
    test_stride_wrap();
    test_ptr_err();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
